// File: rtl/ascon_block_formatter.sv
// Packs an AD/PT byte stream into 64-bit Ascon-128 rate blocks with 10* padding and
// sequences start/data_valid pulses with the init and per-block permutation gaps.
module ascon_block_formatter #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned INIT_CYCLES  = 16,
  parameter int unsigned GAP_CYCLES   = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        msg_start_i,
  input  logic        ad_empty_i,
  input  logic        pt_empty_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_last_i,
  output logic        byte_ready_o,
  output logic        start_o,
  output logic [63:0] data_o,
  output logic        data_valid_o,
  output logic        phase_pt_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_INIT_WAIT, S_COLLECT, S_EMIT, S_GAP, S_PAD, S_DONE
  } state_t;

  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] INIT_LAST  = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [63:0] data_q, data_d;
  logic        ad_empty_q, ad_empty_d;
  logic        pt_empty_q, pt_empty_d;
  logic        phase_pt_q, phase_pt_d;
  logic        phase_end_q, phase_end_d;
  logic        pad_pend_q, pad_pend_d;
  logic [6:0]  sh;
  logic [63:0] base;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      ad_empty_q  <= 1'b0;
      pt_empty_q  <= 1'b0;
      phase_pt_q  <= 1'b0;
      phase_end_q <= 1'b0;
      pad_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      ad_empty_q  <= ad_empty_d;
      pt_empty_q  <= pt_empty_d;
      phase_pt_q  <= phase_pt_d;
      phase_end_q <= phase_end_d;
      pad_pend_q  <= pad_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    ad_empty_d  = ad_empty_q;
    pt_empty_d  = pt_empty_q;
    phase_pt_d  = phase_pt_q;
    phase_end_d = phase_end_q;
    pad_pend_d  = pad_pend_q;
    sh          = {1'b0, idx_q, 3'b000};
    // The first byte of a block clears the stale bytes, so padding can be OR-ed in.
    base        = (idx_q == 3'd0) ? '0 : data_q;

    unique case (state_q)
      S_IDLE: begin
        if (msg_start_i) begin
          state_d     = S_START;
          cnt_d       = '0;
          idx_d       = '0;
          data_d      = '0;
          ad_empty_d  = ad_empty_i;
          pt_empty_d  = pt_empty_i;
          phase_pt_d  = 1'b0;
          phase_end_d = 1'b0;
          pad_pend_d  = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_INIT_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_INIT_WAIT: begin
        if (cnt_q == INIT_LAST) begin
          cnt_d      = '0;
          phase_pt_d = ad_empty_q;
          state_d    = (ad_empty_q && pt_empty_q) ? S_PAD : S_COLLECT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_COLLECT: begin
        cnt_d = '0;
        if (byte_valid_i) begin
          data_d = base | ({byte_i, 56'h0} >> sh);
          idx_d  = idx_q + 3'd1;
          if (byte_last_i) begin
            phase_end_d = 1'b1;
            idx_d       = '0;
            state_d     = S_EMIT;
            if (idx_q == 3'd7) pad_pend_d = 1'b1;
            else data_d = data_d | ({8'h80, 56'h0} >> (sh + 7'd8));
          end else if (idx_q == 3'd7) begin
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (pad_pend_q) begin
            state_d = S_PAD;
          end else if (phase_end_q && phase_pt_q) begin
            state_d = S_DONE;
          end else if (phase_end_q) begin
            phase_pt_d  = 1'b1;
            phase_end_d = 1'b0;
            state_d     = pt_empty_q ? S_PAD : S_COLLECT;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_PAD: begin
        data_d      = 64'h8000_0000_0000_0000;
        pad_pend_d  = 1'b0;
        phase_end_d = 1'b1;
        cnt_d       = '0;
        state_d     = S_EMIT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign byte_ready_o = (state_q == S_COLLECT);
  assign start_o      = (state_q == S_START);
  assign data_valid_o = (state_q == S_EMIT);
  assign done_o       = (state_q == S_DONE);
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign phase_pt_o   = phase_pt_q && busy_o;
  assign data_o       = data_q;

endmodule

// File: tb/tb_ascon_block_formatter.sv
// Randomized scoreboard bench for ascon_block_formatter: a padding model predicts the block
// sequence, a monitor checks blocks, pulse widths and gap timing as the DUT presents them.
`timescale 1ns/1ps
module tb_ascon_block_formatter;
  localparam int unsigned PULSE = 2;
  localparam int unsigned INIT  = 16;
  localparam int unsigned GAP   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg_start_i, ad_empty_i, pt_empty_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i, byte_last_i;
  logic        byte_ready_o, start_o, data_valid_o, phase_pt_o, busy_o, done_o;
  logic [63:0] data_o;

  ascon_block_formatter #(.PULSE_CYCLES(PULSE), .INIT_CYCLES(INIT), .GAP_CYCLES(GAP)) dut (
    .clock_i(clk), .reset_i(rst), .msg_start_i(msg_start_i), .ad_empty_i(ad_empty_i),
    .pt_empty_i(pt_empty_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_last_i(byte_last_i), .byte_ready_o(byte_ready_o), .start_o(start_o),
    .data_o(data_o), .data_valid_o(data_valid_o), .phase_pt_o(phase_pt_o),
    .busy_o(busy_o), .done_o(done_o));

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned done_cnt = 0;
  logic [64:0] exp_q[$];   // {phase_pt, block}
  logic [7:0]  ad_q[$];
  logic [7:0]  pt_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: append 0x80, zero-fill to a multiple of 8 bytes, split into big-endian words.
  task automatic model_phase(input logic [7:0] q[$], input logic pt);
    logic [7:0] tmp[$];
    logic [63:0] w;
    if (q.size() == 0 && !pt) return;
    tmp = q;
    tmp.push_back(8'h80);
    while (tmp.size() % 8 != 0) tmp.push_back(8'h00);
    for (int b = 0; b < tmp.size() / 8; b++) begin
      w = '0;
      for (int j = 0; j < 8; j++) w = (w << 8) | 64'(tmp[b*8+j]);
      exp_q.push_back({pt, w});
    end
  endtask

  // Monitor
  logic        dv_prev = 1'b0, st_prev = 1'b0, watch = 1'b0;
  int unsigned dv_len = 0, st_len = 0, q_cnt = 0;
  logic [63:0] blk = '0;
  logic [64:0] e;
  always @(negedge clk) begin
    if (rst) begin
      dv_prev = 1'b0; st_prev = 1'b0; watch = 1'b0; dv_len = 0; st_len = 0;
    end else begin
      if (!data_valid_o && dv_prev) begin
        chk("dv_width", 64'(dv_len), 64'(PULSE));
        watch = 1'b1; q_cnt = 0;
      end
      if (watch) begin
        q_cnt++;
        if (q_cnt <= GAP)
          chk("gap_quiet", {60'h0, data_o == blk, byte_ready_o, data_valid_o, done_o}, 64'h8);
        else if (byte_ready_o || data_valid_o || done_o)
          watch = 1'b0;
        else if (q_cnt >= GAP + 2) begin
          chk("gap_len", 64'(q_cnt), 64'(GAP + 1));
          watch = 1'b0;
        end
      end
      if (data_valid_o && !dv_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL block_unexpected: got %h expected none", data_o);
        end else begin
          e = exp_q.pop_front();
          chk("block_data", data_o, e[63:0]);
          chk("block_phase", 64'(phase_pt_o), 64'(e[64]));
        end
        blk = data_o; dv_len = 0;
      end
      if (data_valid_o) begin
        dv_len++;
        chk("dv_stable", data_o, blk);
      end
      if (start_o) st_len++;
      if (!start_o && st_prev) begin
        chk("start_width", 64'(st_len), 64'(PULSE));
        st_len = 0;
      end
      if (done_o) begin
        done_cnt++;
        chk("done_busy", 64'(busy_o), 64'd0);
      end
      dv_prev = data_valid_o; st_prev = start_o;
    end
  end

  // Drive one message from ad_q/pt_q; abort_at >= 0 applies reset after that many transfers.
  task automatic run_msg(input int abort_at);
    logic [7:0] sb[$];
    logic       sl[$];
    int         idx, exp_done;
    logic       xfer, lat;
    exp_q.delete();
    model_phase(ad_q, 1'b0);
    model_phase(pt_q, 1'b1);
    foreach (ad_q[i]) begin sb.push_back(ad_q[i]); sl.push_back(i == ad_q.size() - 1); end
    foreach (pt_q[i]) begin sb.push_back(pt_q[i]); sl.push_back(i == pt_q.size() - 1); end
    exp_done = done_cnt + 1;
    @(posedge clk); #1;
    msg_start_i = 1'b1; ad_empty_i = (ad_q.size() == 0); pt_empty_i = (pt_q.size() == 0);
    @(negedge clk);
    chk("start_latency", 64'(start_o), 64'd0);
    @(posedge clk); #1;
    msg_start_i = 1'b0; ad_empty_i = $urandom_range(0, 1); pt_empty_i = $urandom_range(0, 1);
    @(negedge clk);
    chk("start_rise", {62'h0, start_o, busy_o}, 64'h3);
    idx = 0; lat = 1'b0;
    for (int c = 0; c < 5000 && idx < sb.size(); c++) begin
      if (abort_at >= 0 && idx == abort_at) break;
      byte_valid_i = (abort_at >= 0) || ($urandom_range(0, 3) != 0);
      byte_i       = byte_valid_i ? sb[idx] : 8'($urandom);
      byte_last_i  = byte_valid_i ? sl[idx] : 1'($urandom);
      msg_start_i  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      if (lat) chk("last_to_valid", 64'(data_valid_o), 64'd1);
      xfer = byte_valid_i && byte_ready_o;
      lat  = xfer && byte_last_i;
      @(posedge clk); #1;
      if (xfer) idx++;
    end
    byte_valid_i = 1'b0; byte_last_i = 1'b0; msg_start_i = 1'b0;
    if (lat) begin
      @(negedge clk);
      chk("last_to_valid", 64'(data_valid_o), 64'd1);
    end
    if (abort_at >= 0) begin
      chk("abort_progress", 64'(idx), 64'(abort_at));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_outputs", {58'h0, busy_o, done_o, start_o, data_valid_o, byte_ready_o, phase_pt_o}, 64'h0);
      chk("abort_data", data_o, 64'h0);
      exp_q.delete();
      return;
    end
    chk("stream_consumed", 64'(idx), 64'(sb.size()));
    for (int c = 0; c < 3000 && done_cnt != exp_done; c++) @(posedge clk);
    #1;
    chk("done_seen", 64'(done_cnt), 64'(exp_done));
    chk("blocks_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("idle_after_done", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int na, np;
    rst = 1'b1; msg_start_i = 1'b1; ad_empty_i = 1'b0; pt_empty_i = 1'b0;
    byte_i = '0; byte_valid_i = 1'b0; byte_last_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {58'h0, busy_o, done_o, start_o, data_valid_o, byte_ready_o, phase_pt_o}, 64'h0);
    chk("reset_data", data_o, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0; msg_start_i = 1'b0;

    // T1: six AD bytes, empty PT
    ad_q = '{8'h41, 8'h20, 8'h74, 8'h6F, 8'h20, 8'h42}; pt_q = {};
    run_msg(-1);
    // T2: no AD, 23 PT bytes
    ad_q = {};
    pt_q = '{8'h52, 8'h44, 8'h56, 8'h20, 8'h61, 8'h75, 8'h20, 8'h54, 8'h69, 8'h27, 8'h62, 8'h61,
             8'h72, 8'h20, 8'h63, 8'h65, 8'h20, 8'h73, 8'h6F, 8'h69, 8'h72, 8'h20, 8'h3F};
    run_msg(-1);
    // T3: exactly 8 AD bytes, then one PT byte
    ad_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}; pt_q = '{8'hAA};
    run_msg(-1);
    // T4: both empty
    ad_q = {}; pt_q = {};
    run_msg(-1);
    // T5: reset after 3 bytes, then a clean message
    ad_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19}; pt_q = '{8'h01, 8'h02};
    run_msg(3);
    run_msg(-1);
    // Random messages, including 8/16-byte boundaries
    for (int m = 0; m < 20; m++) begin
      na = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20);
      np = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20);
      if (m == 0) begin na = 16; np = 8; end
      ad_q = {}; pt_q = {};
      for (int i = 0; i < na; i++) ad_q.push_back(8'($urandom));
      for (int i = 0; i < np; i++) pt_q.push_back(8'($urandom));
      run_msg(-1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got no completion expected $finish");
    $fatal(1, "timeout");
  end
endmodule
